dds_sweep_ctrl: RTL and testbench

Control block that drives the configuration inputs of the DDS wave generator: waveform select, 20-bit frequency word and 2-bit amplitude code. Debounced key pulses step the waveform and amplitude. A host load port or an autonomous frequency sweep engine, sawtooth or triangle with a programmable dwell per step, sets the frequency. It sits between the key/debounce logic and the wave generator, and all of its outputs are registered.

---
 rtl/dds_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Configuration controller for the DDS wave generator: key-stepped waveform/amplitude,
// manual frequency load, and a sawtooth/triangle frequency sweep with a fixed dwell per step.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_CYCLES = 50_000,
  parameter int unsigned F_MIN        = 1_000,
  parameter int unsigned F_MAX        = 100_000,
  parameter int unsigned F_STEP       = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_sel,
  input  logic        key_amp,
  input  logic        sweep_en,
  input  logic        sweep_mode,
  input  logic [19:0] freq_set,
  input  logic        freq_load,
  output logic [1:0]  wave_sel,
  output logic [19:0] wave_freq,
  output logic [1:0]  wave_a,
  output logic        sweep_active,
  output logic        cfg_update
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  // 21-bit copies so frequency sums and bound compares never wrap
  localparam logic [20:0] FMIN_X  = 21'(F_MIN);
  localparam logic [20:0] FMAX_X  = 21'(F_MAX);
  localparam logic [20:0] FSTEP_X = 21'(F_STEP);
  localparam logic [20:0] FLOW_X  = 21'(F_MIN + F_STEP);

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [19:0]      freq_nxt;
  logic [1:0]       sel_nxt;
  logic [1:0]       amp_nxt;
  logic [20:0]      freq_sum;
  logic             dwell_done;
  logic             cfg_chg;

  function automatic logic [19:0] clamp_freq(input logic [19:0] f);
    logic [20:0] fx;
    fx = {1'b0, f};
    if (fx < FMIN_X)      return FMIN_X[19:0];
    else if (fx > FMAX_X) return FMAX_X[19:0];
    else                  return f;
  endfunction

  assign freq_sum   = {1'b0, wave_freq} + FSTEP_X;
  assign dwell_done = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    freq_nxt  = wave_freq;
    sel_nxt   = wave_sel + {1'b0, key_sel};
    amp_nxt   = wave_a + {1'b0, key_amp};
    case (state)
      MANUAL: begin
        if (sweep_en) begin
          state_nxt = SWEEP_UP;
          freq_nxt  = FMIN_X[19:0];
          cnt_nxt   = '0;
        end else if (freq_load) begin
          freq_nxt = clamp_freq(freq_set);
        end
      end
      SWEEP_UP, SWEEP_DOWN: begin
        if (!sweep_en) begin
          state_nxt = MANUAL;
          cnt_nxt   = '0;
        end else if (!dwell_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
          if (state == SWEEP_UP) begin
            if (!sweep_mode) begin
              freq_nxt = (freq_sum > FMAX_X) ? FMIN_X[19:0] : freq_sum[19:0];
            end else if (freq_sum >= FMAX_X) begin
              freq_nxt  = FMAX_X[19:0];
              state_nxt = SWEEP_DOWN;
            end else begin
              freq_nxt = freq_sum[19:0];
            end
          end else begin
            // Sawtooth in SWEEP_DOWN only happens after a mode change; restart from the bottom
            if (!sweep_mode || ({1'b0, wave_freq} <= FLOW_X)) begin
              freq_nxt  = FMIN_X[19:0];
              state_nxt = SWEEP_UP;
            end else begin
              freq_nxt = wave_freq - FSTEP_X[19:0];
            end
          end
        end
      end
      default: begin
        state_nxt = MANUAL;
        cnt_nxt   = '0;
      end
    endcase
    cfg_chg = (sel_nxt != wave_sel) || (amp_nxt != wave_a) || (freq_nxt != wave_freq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MANUAL;
      cnt          <= '0;
      wave_sel     <= '0;
      wave_a       <= '0;
      wave_freq    <= FMIN_X[19:0];
      sweep_active <= 1'b0;
      cfg_update   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      wave_sel     <= sel_nxt;
      wave_a       <= amp_nxt;
      wave_freq    <= freq_nxt;
      sweep_active <= (state_nxt != MANUAL);
      cfg_update   <= cfg_chg;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed scenarios with literal expectations, then a random
// run, all checked every cycle against a behavioural model of the controller.
module tb_dds_sweep_ctrl;

  localparam int DW    = 4;
  localparam int FMIN  = 100;
  localparam int FMAX  = 130;
  localparam int FSTEP = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_sel, key_amp, sweep_en, sweep_mode, freq_load;
  logic [19:0] freq_set;
  logic [1:0]  wave_sel, wave_a;
  logic [19:0] wave_freq;
  logic        sweep_active, cfg_update;

  dds_sweep_ctrl #(
    .DWELL_CYCLES(DW), .F_MIN(FMIN), .F_MAX(FMAX), .F_STEP(FSTEP)
  ) dut (
    .clk(clk), .rst(rst), .key_sel(key_sel), .key_amp(key_amp),
    .sweep_en(sweep_en), .sweep_mode(sweep_mode), .freq_set(freq_set),
    .freq_load(freq_load), .wave_sel(wave_sel), .wave_freq(wave_freq),
    .wave_a(wave_a), .sweep_active(sweep_active), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: mode 0 = manual, 1 = sweeping upward, 2 = sweeping downward
  int m_sel, m_amp, m_freq, m_mode, m_dwell, m_upd, m_act;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int o_sel, o_amp, o_freq;
    o_sel = m_sel; o_amp = m_amp; o_freq = m_freq;
    if (rst) begin
      m_sel = 0; m_amp = 0; m_freq = FMIN; m_mode = 0; m_dwell = 0;
      m_upd = 0; m_act = 0;
      return;
    end
    m_sel = (m_sel + int'(key_sel)) % 4;
    m_amp = (m_amp + int'(key_amp)) % 4;
    if (m_mode == 0) begin
      if (sweep_en) begin
        m_mode = 1; m_freq = FMIN; m_dwell = 0;
      end else if (freq_load) begin
        m_freq = int'(freq_set);
        if (m_freq < FMIN) m_freq = FMIN;
        if (m_freq > FMAX) m_freq = FMAX;
      end
    end else if (!sweep_en) begin
      m_mode = 0; m_dwell = 0;
    end else begin
      m_dwell++;
      if (m_dwell == DW) begin
        m_dwell = 0;
        if (m_mode == 1 && !sweep_mode)
          m_freq = (m_freq + FSTEP > FMAX) ? FMIN : m_freq + FSTEP;
        else if (m_mode == 1) begin
          if (m_freq + FSTEP >= FMAX) begin m_freq = FMAX; m_mode = 2; end
          else m_freq = m_freq + FSTEP;
        end else if (!sweep_mode || m_freq <= FMIN + FSTEP) begin
          m_freq = FMIN; m_mode = 1;
        end else m_freq = m_freq - FSTEP;
      end
    end
    m_upd = (m_sel != o_sel || m_amp != o_amp || m_freq != o_freq) ? 1 : 0;
    m_act = (m_mode != 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sel",  32'(wave_sel),     m_sel);
    chk("model_amp",  32'(wave_a),       m_amp);
    chk("model_freq", 32'(wave_freq),    m_freq);
    chk("model_act",  32'(sweep_active), m_act);
    chk("model_upd",  32'(cfg_update),   m_upd);
  endtask

  int saw_seq[5] = '{110, 120, 130, 100, 110};
  int tri_seq[8] = '{110, 120, 130, 120, 110, 100, 110, 120};
  int ld_val[4]  = '{115, 20, 500, 500};
  int ld_exp[4]  = '{115, 100, 130, 130};
  int ld_upd[4]  = '{1, 1, 1, 0};

  initial begin
    rst = 1'b1; key_sel = 0; key_amp = 0; sweep_en = 0; sweep_mode = 0;
    freq_load = 0; freq_set = '0;
    m_sel = 0; m_amp = 0; m_freq = FMIN; m_mode = 0; m_dwell = 0; m_upd = 0; m_act = 0;
    tick(); tick();
    chk("rst_sel", 32'(wave_sel), 0);
    chk("rst_freq", 32'(wave_freq), FMIN);
    chk("rst_amp", 32'(wave_a), 0);
    chk("rst_act", 32'(sweep_active), 0);
    chk("rst_upd", 32'(cfg_update), 0);
    rst = 1'b0;
    tick();

    // Key stepping; amplitude key coincides with two of the select presses
    for (int i = 0; i < 5; i++) begin
      key_sel = 1; key_amp = (i == 1 || i == 3);
      tick();
      chk("key_sel_val", 32'(wave_sel), (i + 1) % 4);
      chk("key_upd", 32'(cfg_update), 1);
      key_sel = 0; key_amp = 0;
      tick();
      chk("key_upd_idle", 32'(cfg_update), 0);
    end
    chk("key_amp_val", 32'(wave_a), 2);

    for (int i = 0; i < 4; i++) begin
      freq_set = 20'(ld_val[i]); freq_load = 1;
      tick();
      chk("load_freq", 32'(wave_freq), ld_exp[i]);
      chk("load_upd", 32'(cfg_update), ld_upd[i]);
      freq_load = 0;
      tick();
    end

    // Sawtooth sweep, load pulse coinciding with the enable is dropped
    sweep_mode = 0; sweep_en = 1; freq_load = 1; freq_set = 20'd125;
    tick();
    freq_load = 0;
    chk("saw_entry", 32'(wave_freq), FMIN);
    chk("saw_act", 32'(sweep_active), 1);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < DW - 1; c++) begin
        tick();
        chk("saw_hold_upd", 32'(cfg_update), 0);
      end
      tick();
      chk("saw_step", 32'(wave_freq), saw_seq[k]);
      chk("saw_step_upd", 32'(cfg_update), 1);
    end

    sweep_en = 0;
    tick();
    chk("saw_exit_act", 32'(sweep_active), 0);
    chk("saw_exit_freq", 32'(wave_freq), 110);

    // Triangle sweep with a load pulse that must be ignored
    sweep_mode = 1; sweep_en = 1;
    tick();
    chk("tri_entry", 32'(wave_freq), FMIN);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < DW; c++) begin
        freq_load = (k == 1 && c == 1); freq_set = 20'd125;
        tick();
      end
      freq_load = 0;
      chk("tri_step", 32'(wave_freq), tri_seq[k]);
    end
    sweep_en = 0;
    tick();
    chk("tri_exit_act", 32'(sweep_active), 0);
    chk("tri_exit_freq", 32'(wave_freq), 120);
    tick();
    chk("tri_hold_freq", 32'(wave_freq), 120);

    // Reset in SWEEP_DOWN with a coincident key press
    sweep_en = 1;
    tick();
    for (int c = 0; c < 3 * DW + 2; c++) tick();
    chk("pre_rst_freq", 32'(wave_freq), 130);
    rst = 1; key_sel = 1;
    tick();
    chk("mid_rst_sel", 32'(wave_sel), 0);
    chk("mid_rst_freq", 32'(wave_freq), FMIN);
    chk("mid_rst_amp", 32'(wave_a), 0);
    chk("mid_rst_act", 32'(sweep_active), 0);
    chk("mid_rst_upd", 32'(cfg_update), 0);
    rst = 0; key_sel = 0; sweep_en = 0;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(199) == 0);
      key_sel   = ($urandom_range(3) == 0);
      key_amp   = ($urandom_range(3) == 0);
      freq_load = ($urandom_range(4) == 0);
      freq_set  = ($urandom_range(1) == 0) ? 20'($urandom_range(200)) : 20'($urandom);
      if ($urandom_range(39) == 0) sweep_en = ~sweep_en;
      if ($urandom_range(19) == 0) sweep_mode = ~sweep_mode;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
